// File: rtl/rvcpu_pkg.sv
// Shared CPU-wide constants and types used by the fetch front end.
package rvcpu;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with flush and occupancy count.
module fetch_fifo
    import rvcpu::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = push && (r_count != CW'(DEPTH));
    assign w_pop  = pop && (r_count != {CW{1'b0}});

    // Storage is cleared on reset so the presented head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally on the power-of-two depth.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1'b1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: credit-limited sequential requests, in-order response
// buffering and redirect with discard of stale in-flight responses.
module ifetch
    import rvcpu::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = rvcpu::RESET_PC,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_drop;
    logic [CW-1:0]   w_count;
    logic [CW:0]     w_used;
    logic            w_credit;
    logic            w_req_fire;
    logic            w_rsp_take;
    logic            w_rsp_keep;
    logic            w_pop;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

    // Outstanding requests plus buffered entries never exceed DEPTH, so every response has a slot.
    assign w_used     = {1'b0, r_inflight} + {1'b0, w_count};
    assign w_credit   = w_used < (CW + 1)'(DEPTH);
    assign imem_req_valid = rst_n && !redirect_valid && w_credit;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding (e.g. from before a reset) are ignored.
    assign w_rsp_take = imem_rsp_valid && (r_inflight != {CW{1'b0}});
    assign w_rsp_keep = w_rsp_take && (r_drop == {CW{1'b0}}) && !redirect_valid;
    assign w_pop      = instr_valid && instr_ready;
    assign w_push_entry = '{pc: r_rsp_pc, instr: imem_rsp_data};

    // PC and outstanding-request bookkeeping; a redirect overrides every other update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_inflight <= {CW{1'b0}};
            r_drop     <= {CW{1'b0}};
        end else if (redirect_valid) begin
            r_fetch_pc <= word_align(redirect_pc);
            r_rsp_pc   <= word_align(redirect_pc);
            r_inflight <= r_inflight - CW'(w_rsp_take);
            r_drop     <= r_inflight - CW'(w_rsp_take);
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_rsp_take && (r_drop != {CW{1'b0}})) begin
                r_drop <= r_drop - CW'(1'b1);
            end
            if (w_rsp_keep) begin
                r_rsp_pc <= r_rsp_pc + 32'd4;
            end
            r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_rsp_take);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (w_rsp_keep),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count)
    );

    assign instr_valid = (w_count != {CW{1'b0}});
    assign instr       = w_head.instr;
    assign instr_pc    = w_head.pc;

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: a behavioural memory and expected-stream model drive
// randomized traffic, and a separate monitor checks every delivered instruction.
module tb_ifetch;
    import rvcpu::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic        redirect_valid, instr_valid, instr_ready;
    logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, instr, instr_pc;

    ifetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    typedef struct { int due; logic [31:0] data; } rsp_t;

    exp_t        exp_q[$];
    rsp_t        pend[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat_max = 1;
    int          nreq = 0;
    int          first_valid = -1;
    int          c0, r0;
    bit          arm = 1'b0;
    logic        prev_rst_n = 1'b1;
    logic [31:0] model_pc = RPC;
    logic        pv = 1'b0, pr = 1'b0, pev = 1'b1;
    logic [31:0] ppc = 32'd0, pins = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: memory drives its response, then the model books the handshakes.
    task automatic tick();
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend[0].data;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        @(negedge clk);
        #1;
        if (imem_rsp_valid) void'(pend.pop_front());
        if (!rst_n) begin
            chk("req_valid_in_reset", 32'(imem_req_valid), 32'd0);
            if (!prev_rst_n) begin
                chk("instr_valid_in_reset", 32'(instr_valid), 32'd0);
                chk("instr_in_reset", instr, 32'd0);
                chk("instr_pc_in_reset", instr_pc, 32'd0);
            end
            exp_q.delete();
            model_pc = RPC;
        end else if (redirect_valid) begin
            chk("req_valid_on_redirect", 32'(imem_req_valid), 32'd0);
            exp_q.delete();
            model_pc    = {redirect_pc[31:2], 2'b00};
            arm         = 1'b1;
            first_valid = -1;
        end else if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, model_pc);
            exp_q.push_back('{pc: model_pc, data: mem_word(model_pc)});
            pend.push_back('{due: cyc + $urandom_range(lat_max, 1), data: mem_word(imem_req_addr)});
            model_pc = model_pc + 32'd4;
            nreq++;
        end
        prev_rst_n = rst_n;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Monitor: pops the expected stream on every instruction handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && pv && !pr && !pev) begin
                chk("instr_valid_hold", 32'(instr_valid), 32'd1);
                chk("instr_pc_hold", instr_pc, ppc);
                chk("instr_hold", instr, pins);
            end
            if (rst_n && arm && instr_valid) begin
                first_valid = cyc;
                arm = 1'b0;
            end
            if (rst_n && instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got pc %h expected none (cycle %0d)", instr_pc, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("instr_pc", instr_pc, mon_e.pc);
                    chk("instr", instr, mon_e.data);
                end
            end
            pv   = instr_valid;
            pr   = instr_ready;
            pev  = redirect_valid || !rst_n;
            ppc  = instr_pc;
            pins = instr;
        end
    end

    initial begin
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        redirect_valid = 1'b0; redirect_pc = 32'd0; instr_ready = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) tick();

        // Streaming from reset with 1-cycle memory.
        rst_n = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1; lat_max = 1;
        arm = 1'b1; first_valid = -1; c0 = cyc; nreq = 0;
        tick();
        chk("first_cycle_request", 32'(nreq), 32'd1);
        repeat (7) tick();
        chk("first_instr_latency", 32'(first_valid - c0), 32'd2);
        chk("stream_rate", 32'(nreq), 32'd8);

        // Redirect coinciding with a response and an instr handshake.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; r0 = cyc;
        tick();
        redirect_valid = 1'b0;
        repeat (6) tick();
        chk("redirect_latency", 32'(first_valid - r0), 32'd3);

        // Redirect near the top of the address space, unaligned.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        repeat (6) tick();

        // Back-pressure: exactly DEPTH requests, then drain in order.
        rst_n = 1'b0; imem_req_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b0; nreq = 0;
        repeat (10) tick();
        chk("stall_req_count", 32'(nreq), 32'(DEPTH));
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        instr_ready = 1'b1;
        repeat (10) tick();

        // Randomized traffic with variable memory latency, redirects and resets.
        lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            imem_req_ready = ($urandom_range(3, 0) != 0);
            instr_ready    = ($urandom_range(3, 0) != 0);
            redirect_valid = ($urandom_range(24, 0) == 0);
            redirect_pc    = ($urandom_range(7, 0) == 0) ?
                             (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
            if ($urandom_range(299, 0) == 0) begin
                redirect_valid = 1'b0;
                rst_n = 1'b0;
                for (int k = 0; k < 20 && (k < 2 || pend.size() > 0); k++) tick();
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        // Drain everything still expected.
        imem_req_ready = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0;
        for (int k = 0; k < 100 && (exp_q.size() > 0 || pend.size() > 0); k++) tick();
        chk("final_drain", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
